inst_mem_loader: RTL and testbench
==================================

// Module: inst_mem_loader
// PURPOSE
//  Boot-time writer for the instruction memory that the fetch/decode stage reads at pc>>2.
//  Receives a byte stream over valid/ready: a 2-byte little-endian word count, then little-endian
//  32-bit instruction words. Issues one memory write per word at byte address word_idx<<2.
//  Holds the CPU (cpu_hold) until a complete, legal program has been written.
// PARAMETERS
//  DEPTH    64  instruction memory depth in words; largest legal word count
//  CNT_W    7   width of words_loaded; must satisfy 2**CNT_W > DEPTH
// PORTS
//  clk          in   1   system clock; all state changes on rising edge
//  rst          in   1   reset, asynchronous, active-low (0 = reset)
//  start        in   1   single-cycle request to begin a load
//  in_valid     in   1   byte stream valid
//  in_data      in   8   byte stream data
//  in_ready     out  1   loader accepts a byte this cycle
//  mem_we       out  1   instruction memory write enable, one-cycle pulse per word
//  mem_addr     out  32  write byte address (word_idx<<2, word aligned)
//  mem_wdata    out  32  assembled instruction word
//  cpu_hold     out  1   1 = keep CPU/PC in reset
//  busy         out  1   load in progress (states LEN0, LEN1, DATA, WRITE)
//  done         out  1   level: last load completed legally
//  error        out  1   level: last load rejected (count > DEPTH)
//  words_loaded out  CNT_W  words written in current/last load
// BEHAVIOUR
//  Reset (rst=0, immediate): state=IDLE; in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0,
//   cpu_hold=1, busy=0, done=0, error=0, words_loaded=0. Words already written stay in memory.
//  Byte transfer = in_valid & in_ready at rising edge. in_ready=1 only in LEN0, LEN1, DATA.
//  States:
//   IDLE  : start -> LEN0 (clears done/error/words_loaded, byte_cnt=0).
//   LEN0  : accept byte -> len[7:0]; -> LEN1.
//   LEN1  : accept byte -> len[15:8]; len==0 -> DONE; len>DEPTH -> ERR; else -> DATA.
//   DATA  : k-th accepted byte (k=0..3) -> mem_wdata[8k+7:8k]; 4th byte -> WRITE.
//   WRITE : mem_we=1 exactly this cycle, mem_addr=words_loaded<<2, in_ready=0;
//           words_loaded++ at end of cycle; if words_loaded+1==len -> DONE else DATA.
//   DONE  : done=1, cpu_hold=0; start -> LEN0 (cpu_hold back to 1 next cycle).
//   ERR   : error=1, cpu_hold=1; no writes; start -> LEN0.
//  cpu_hold=0 only in DONE. busy=1 in LEN0, LEN1, DATA, WRITE.
//  Latency: 4th byte of word accepted in cycle n -> mem_we in cycle n+1; at most 1 byte per cycle,
//   so max rate 4 bytes per 5 cycles. in_valid gaps stall any state without side effects.
//  start while busy is ignored. Bytes offered in IDLE/DONE/ERR are not accepted (in_ready=0).
//  mem_wdata/mem_addr hold their last values outside WRITE; only mem_we qualifies them.
//  Length compare is 16-bit unsigned; word index never exceeds DEPTH-1, so no address wrap.
//  rst asserted mid-load: immediate return to reset values; no partial word is written.
// TESTING
//  1 Reset: rst=0 -> cpu_hold=1, in_ready=0, mem_we=0, done=0, error=0, words_loaded=0.
//  2 start; bytes 02 00 13 01 01 fe 23 2e 81 00 -> mem_we@addr 0x0 data 0xfe010113,
//    mem_we@addr 0x4 data 0x00812e23; then done=1, cpu_hold=0, words_loaded=2.
//  3 start; bytes 00 00 -> DONE cycle after 2nd byte, no mem_we, cpu_hold=0, words_loaded=0.
//  4 start; bytes 41 00 (65>DEPTH) -> error=1, cpu_hold=1, no mem_we; new start + 01 00 13 00 00 00
//    -> write addr 0x0 data 0x00000013, error=0, done=1.
//  5 Gapped in_valid + start pulse mid-load -> same writes as case 2; in_ready=0 in WRITE cycles;
//    start ignored; exactly 2 mem_we pulses.
//  6 rst low after 2 data bytes of word 1 -> immediate reset values, no mem_we; reload succeeds.

Source files
------------

// File: rtl/inst_mem_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : inst_mem_loader_if
//  Purpose  : Byte-stream input handshake plus instruction-memory write port
//             used by the boot-time instruction memory loader.
//  Revision : 1.0  initial release
// ============================================================================
interface inst_mem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  // Loader side: consumes the byte stream and drives the memory write port.
  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  // Environment side: produces bytes and observes the memory writes.
  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/inst_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : inst_mem_loader
//  Purpose  : Boot-time writer for instruction memory. Receives a 16-bit LE
//             word count followed by LE 32-bit words over valid/ready and
//             issues one memory write per word; holds the CPU until a
//             complete, legal program has been written.
//  Revision : 1.0  initial release
// ============================================================================
module inst_mem_loader #(
  parameter int DEPTH = 64,
  parameter int CNT_W = 7
) (
  input  wire logic             clk,
  input  wire logic             rst,      // asynchronous, active-low
  input  wire logic             start,
  inst_mem_loader_if.slave      bus,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [CNT_W-1:0]      words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN0  = 3'd1,
    S_LEN1  = 3'd2,
    S_DATA  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  localparam logic [15:0] DEPTH_W = 16'(DEPTH);

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       addr_q, addr_d;
  logic [CNT_W-1:0]  words_q, words_d;

  logic              accept;
  logic [15:0]       len_full;

  assign accept   = bus.in_valid & bus.in_ready;
  // Full 16-bit count as it becomes known when the high byte arrives.
  assign len_full = {bus.in_data, len_q[7:0]};

  // Outputs are pure state decodes; address/data are registered and simply
  // hold between writes, qualified only by mem_we.
  assign bus.in_ready  = (state_q == S_LEN0) || (state_q == S_LEN1) || (state_q == S_DATA);
  assign bus.mem_we    = (state_q == S_WRITE);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign cpu_hold      = (state_q != S_DONE);
  assign busy          = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                         (state_q == S_DATA) || (state_q == S_WRITE);
  assign done          = (state_q == S_DONE);
  assign error         = (state_q == S_ERR);
  assign words_loaded  = words_q;

  // State register and datapath flops; reset leaves memory contents alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      byte_cnt_q <= '0;
      wdata_q    <= '0;
      addr_q     <= '0;
      words_q    <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      wdata_q    <= wdata_d;
      addr_q     <= addr_d;
      words_q    <= words_d;
    end
  end

  // Next-state and datapath update; start is only honoured when not busy.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    wdata_d    = wdata_q;
    addr_d     = addr_q;
    words_d    = words_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LEN0;
          words_d    = '0;
          byte_cnt_d = '0;
        end
      end
      S_LEN0: begin
        if (accept) begin
          len_d[7:0] = bus.in_data;
          state_d    = S_LEN1;
        end
      end
      S_LEN1: begin
        if (accept) begin
          len_d[15:8] = bus.in_data;
          if (len_full == 16'd0) begin
            state_d = S_DONE;
          end else if (len_full > DEPTH_W) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          wdata_d[{byte_cnt_q, 3'b000} +: 8] = bus.in_data;
          byte_cnt_d                         = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            // Address is latched here so it is stable for the whole WRITE cycle.
            addr_d  = {{(32-CNT_W-2){1'b0}}, words_q, 2'b00};
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        words_d = words_q + 1'b1;
        if ((16'(words_q) + 16'd1) == len_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DATA;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inst_mem_loader
//  Purpose  : Directed self-checking bench for inst_mem_loader.
//  Revision : 1.0  initial release
// ============================================================================
module tb_inst_mem_loader;

  logic       clk;
  logic       rst;
  logic       start;
  logic       cpu_hold;
  logic       busy;
  logic       done;
  logic       error;
  logic [6:0] words_loaded;

  inst_mem_loader_if bus ();

  inst_mem_loader #(.DEPTH(64), .CNT_W(7)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .bus          (bus.slave),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  int checks = 0;
  int errors = 0;
  int rdy_viol = 0;
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write pulse and whether in_ready was wrongly high with it.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wa_q.push_back(bus.mem_addr);
      wd_q.push_back(bus.mem_wdata);
      if (bus.in_ready !== 1'b0) rdy_viol++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    bus.in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (bus.in_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("byte_accept_bound", 32'(t < 20), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [7:0] prog2 [10];
    prog2 = '{8'h02, 8'h00, 8'h13, 8'h01, 8'h01, 8'hfe, 8'h23, 8'h2e, 8'h81, 8'h00};

    rst          = 1'b0;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    idle(2);

    // Reset state
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    idle(1);

    // Bytes offered in IDLE are not accepted
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    chk("idle_in_ready", 32'(bus.in_ready), 32'd0);
    idle(1);
    bus.in_valid = 1'b0;

    // Two-word program
    wa_q.delete(); wd_q.delete();
    pulse_start();
    chk("c2_busy", 32'(busy), 32'd1);
    chk("c2_hold_loading", 32'(cpu_hold), 32'd1);
    for (int i = 0; i < 10; i++) send_byte(prog2[i], 0);
    idle(1);
    chk("c2_nwrites", 32'(wa_q.size()), 32'd2);
    chk("c2_w0_addr", wa_q[0], 32'h0000_0000);
    chk("c2_w0_data", wd_q[0], 32'hfe01_0113);
    chk("c2_w1_addr", wa_q[1], 32'h0000_0004);
    chk("c2_w1_data", wd_q[1], 32'h0081_2e23);
    chk("c2_done", 32'(done), 32'd1);
    chk("c2_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("c2_words", 32'(words_loaded), 32'd2);
    chk("c2_busy_end", 32'(busy), 32'd0);
    chk("c2_addr_hold", bus.mem_addr, 32'h0000_0004);
    chk("c2_data_hold", bus.mem_wdata, 32'h0081_2e23);

    // Zero-length load
    wa_q.delete(); wd_q.delete();
    pulse_start();
    chk("c3_hold_again", 32'(cpu_hold), 32'd1);
    chk("c3_done_cleared", 32'(done), 32'd0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    chk("c3_done", 32'(done), 32'd1);
    chk("c3_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("c3_words", 32'(words_loaded), 32'd0);
    idle(2);
    chk("c3_nwrites", 32'(wa_q.size()), 32'd0);

    // Over-length rejection, then recovery
    wa_q.delete(); wd_q.delete();
    pulse_start();
    send_byte(8'h41, 0);
    send_byte(8'h00, 0);
    chk("c4_error", 32'(error), 32'd1);
    chk("c4_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("c4_done", 32'(done), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h13;
    chk("c4_err_in_ready", 32'(bus.in_ready), 32'd0);
    idle(2);
    bus.in_valid = 1'b0;
    chk("c4_nwrites_err", 32'(wa_q.size()), 32'd0);
    pulse_start();
    chk("c4_error_cleared", 32'(error), 32'd0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    idle(1);
    chk("c4_nwrites", 32'(wa_q.size()), 32'd1);
    chk("c4_w0_addr", wa_q[0], 32'h0000_0000);
    chk("c4_w0_data", wd_q[0], 32'h0000_0013);
    chk("c4_error_end", 32'(error), 32'd0);
    chk("c4_done_end", 32'(done), 32'd1);
    chk("c4_words", 32'(words_loaded), 32'd1);

    // Gapped stream with start pulses mid-load
    wa_q.delete(); wd_q.delete();
    rdy_viol = 0;
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      send_byte(prog2[i], (i % 3) + 1);
      if (i == 4 || i == 5) pulse_start();
    end
    idle(3);
    chk("c5_nwrites", 32'(wa_q.size()), 32'd2);
    chk("c5_w0_addr", wa_q[0], 32'h0000_0000);
    chk("c5_w0_data", wd_q[0], 32'hfe01_0113);
    chk("c5_w1_addr", wa_q[1], 32'h0000_0004);
    chk("c5_w1_data", wd_q[1], 32'h0081_2e23);
    chk("c5_ready_in_write", 32'(rdy_viol), 32'd0);
    chk("c5_done", 32'(done), 32'd1);
    chk("c5_words", 32'(words_loaded), 32'd2);

    // Reset in the middle of a word
    wa_q.delete(); wd_q.delete();
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(prog2[i], 0);
    rst = 1'b0;
    #1;
    chk("c6_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("c6_in_ready", 32'(bus.in_ready), 32'd0);
    chk("c6_busy", 32'(busy), 32'd0);
    chk("c6_words", 32'(words_loaded), 32'd0);
    chk("c6_wdata", bus.mem_wdata, 32'h0000_0000);
    chk("c6_addr", bus.mem_addr, 32'h0000_0000);
    idle(2);
    rst = 1'b1;
    idle(2);
    chk("c6_nwrites_rst", 32'(wa_q.size()), 32'd0);
    pulse_start();
    for (int i = 0; i < 10; i++) send_byte(prog2[i], 0);
    idle(1);
    chk("c6_nwrites", 32'(wa_q.size()), 32'd2);
    chk("c6_w0_data", wd_q[0], 32'hfe01_0113);
    chk("c6_w1_addr", wa_q[1], 32'h0000_0004);
    chk("c6_w1_data", wd_q[1], 32'h0081_2e23);
    chk("c6_done", 32'(done), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
